// File: rtl/ins_store_loader_if.sv
// Byte-stream and instruction-store write port bundle for ins_store_loader.
// master: the loader side (consumes bytes, drives the store write port).
// slave:  the host/store side (drives bytes, observes the store write port).
interface ins_store_loader_if #(
  parameter int AW = 6
) ();
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          st_we;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, st_we, st_addr, st_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, st_we, st_addr, st_wdata
  );
endinterface

// File: rtl/ins_store_loader.sv
// Instruction store loader: assembles little-endian 32-bit words from a
// valid/ready byte stream and writes them to consecutive store addresses,
// holding the core in reset while loading.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module ins_store_loader #(
  parameter int AW = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  ins_store_loader_if.master  bus,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic [AW:0]         words_written,
  output logic                err
);

  localparam logic [AW:0] MAX_WORDS = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr;
  logic [1:0]    idx;
  logic [31:0]   asm_word;
  logic [AW:0]   len_q;
  logic [AW:0]   len_in;
  logic          hs;
  logic          last_word;
  logic          start_ok;

  assign hs        = bus.in_valid & bus.in_ready;
  assign len_in    = bus.in_data[AW:0];
  assign last_word = (words_written + (AW+1)'(1)) == len_q;
  assign start_ok  = start & ((state == IDLE) | (state == DONE));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = LEN;
      LEN:   if (hs) state_nx = DATA;
      DATA:  if (hs && idx == 2'd3) state_nx = WRITE;
`ifdef LOADER_CHECKSUM_EN
      WRITE: state_nx = last_word ? CSUM : DATA;
`else
      WRITE: state_nx = last_word ? DONE : DATA;
`endif
      CSUM:  if (hs) state_nx = DONE;
      DONE:  if (start) state_nx = LEN;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
    bus.st_we    = (state == WRITE);
    bus.st_addr  = addr;
    bus.st_wdata = asm_word;
    busy         = (state != IDLE) && (state != DONE);
    done         = (state == DONE);
    cpu_rst      = busy | rst;
  end

  // Length latch, byte assembly, address and word counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      idx           <= '0;
      asm_word      <= '0;
      len_q         <= '0;
      words_written <= '0;
    end else begin
      if (start_ok) begin
        addr          <= '0;
        idx           <= '0;
        words_written <= '0;
      end
      if (state == LEN && hs)
        len_q <= (len_in == '0 || len_in > MAX_WORDS) ? MAX_WORDS : len_in;
      if (state == DATA && hs) begin
        asm_word[{idx, 3'b000} +: 8] <= bus.in_data;
        idx                          <= idx + 2'd1;
      end
      if (state == WRITE) begin
        addr          <= addr + AW'(1);
        words_written <= words_written + (AW+1)'(1);
        idx           <= '0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of data bytes, compared against the trailing byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (start_ok) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (state == DATA && hs) begin
      csum <= csum ^ bus.in_data;
    end else if (state == CSUM && hs) begin
      err <= (bus.in_data != csum);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ins_store_loader.sv
// Self-checking bench for ins_store_loader: table of length cases plus
// random-length loads against a word-list reference, and hand sequences
// for reset, start-ignore and checksum corners.
module tb_ins_store_loader;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cpu_rst, busy, done, err;
  logic [AW:0]   words_written;

  ins_store_loader_if #(.AW(AW)) bus ();

  ins_store_loader #(.AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bus           (bus),
    .cpu_rst       (cpu_rst),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         cap[$];
  logic [31:0] exp_q[$];
  bit          prev_we = 1'b0;
  int          we_b2b = 0;
  int          cpu_rst_bad = 0;

  // Store-port monitor: records every write, flags back-to-back st_we
  // and any cycle where cpu_rst differs from busy outside reset.
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (bus.st_we) cap.push_back('{bus.st_addr, bus.st_wdata});
      if (bus.st_we && prev_we) we_b2b++;
      prev_we = bus.st_we;
      if (cpu_rst != busy) cpu_rst_bad++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Words a load writes for a given length byte: low AW+1 bits, 0 or >2^AW -> 2^AW.
  function automatic int model_len(input logic [7:0] b);
    int n;
    n = int'(b) % (1 << (AW + 1));
    if (n == 0 || n > (1 << AW)) n = 1 << AW;
    return n;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input string nm);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 50; n++) begin
      if (bus.in_ready) begin
        acc = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!acc) chk({nm, "_handshake_timeout"}, 32'(acc), 1);
  endtask

  task automatic pulse_start(input string nm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_start_in_ready"}, bus.in_ready, 1);
    chk({nm, "_start_done_clr"}, done, 0);
    chk({nm, "_start_err_clr"}, err, 0);
    chk({nm, "_start_cpu_rst"}, cpu_rst, 1);
  endtask

  // Sends the words in exp_q as one load and checks the store writes.
  task automatic do_load(input logic [7:0] len_b, input int max_gap,
                         input bit bad_csum, input bit start_mid, input string nm);
    logic [31:0] w;
    logic [7:0]  x;
    int          nw;
    bit          exp_err;
    x       = 8'h00;
    nw      = exp_q.size();
    exp_err = 1'b0;
    cap.delete();
    pulse_start(nm);
    send_byte(len_b, $urandom_range(0, max_gap), nm);
    for (int i = 0; i < nw; i++) begin
      w = exp_q[i];
      for (int b = 0; b < 4; b++) begin
        x = x ^ w[8*b +: 8];
        send_byte(w[8*b +: 8], $urandom_range(0, max_gap), nm);
        if (b == 3) begin
          chk($sformatf("%s_we_latency_w%0d", nm, i), bus.st_we, 1);
          chk($sformatf("%s_ready_low_in_write_w%0d", nm, i), bus.in_ready, 0);
        end
        if (start_mid && i == 0 && b == 0) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
`ifdef LOADER_CHECKSUM_EN
    exp_err = bad_csum;
    send_byte(bad_csum ? (x ^ 8'h01) : x, $urandom_range(0, max_gap), nm);
`endif
    for (int n = 0; n < 20 && !done; n++) @(negedge clk);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, 32'(exp_err));
    chk({nm, "_words_written"}, words_written, nw);
    chk({nm, "_write_count"}, cap.size(), nw);
    for (int i = 0; i < nw && i < cap.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), cap[i].addr, i % (1 << AW));
      chk($sformatf("%s_data%0d", nm, i), cap[i].data, exp_q[i]);
    end
  endtask

  typedef struct {
    logic [7:0] len_b;
    int         exp_n;
    int         max_gap;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl = '{
      '{8'h00, 64, 0},
      '{8'h03,  3, 3},
      '{8'h40, 64, 1},
      '{8'h41, 64, 0},
      '{8'hFF, 64, 0},
      '{8'h82,  2, 2},
      '{8'h3F, 63, 0}
    };

    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_st_we", bus.st_we, 0);
    chk("rst_st_addr", bus.st_addr, 0);
    chk("rst_st_wdata", bus.st_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words_written", words_written, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_cpu_rst", cpu_rst, 0);

    // Reset in the middle of a word: nothing is written.
    cap.delete();
    pulse_start("midrst");
    send_byte(8'h02, 0, "midrst");
    send_byte(8'hAA, 0, "midrst");
    send_byte(8'hBB, 1, "midrst");
    rst = 1'b1;
    #1;
    chk("midrst_st_we", bus.st_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_words_written", words_written, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_writes", cap.size(), 0);
    chk("midrst_done", done, 0);

    // Single word, fixed bytes 13 05 00 00.
    exp_q.delete();
    exp_q.push_back(32'h00000513);
    do_load(8'h01, 0, 1'b0, 1'b0, "single");

    // Three words with idle gaps and a start pulse during DATA.
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back($urandom);
    do_load(8'h03, 3, 1'b0, 1'b1, "three");

    // Length table.
    foreach (tbl[k]) begin
      chk($sformatf("tbl%0d_model_len", k), model_len(tbl[k].len_b), tbl[k].exp_n);
      exp_q.delete();
      for (int i = 0; i < tbl[k].exp_n; i++) exp_q.push_back($urandom);
      do_load(tbl[k].len_b, tbl[k].max_gap, 1'b0, 1'b0, $sformatf("tbl%0d", k));
    end

    // Random lengths and data.
    for (int r = 0; r < 3; r++) begin
      logic [7:0] lb;
      lb = 8'($urandom);
      exp_q.delete();
      for (int i = 0; i < model_len(lb); i++) exp_q.push_back($urandom);
      do_load(lb, 2, 1'b0, 1'b0, $sformatf("rnd%0d", r));
    end

`ifdef LOADER_CHECKSUM_EN
    exp_q.delete();
    exp_q.push_back(32'h04030201);
    do_load(8'h01, 0, 1'b0, 1'b0, "csum_ok");
    do_load(8'h01, 0, 1'b1, 1'b0, "csum_bad");
`endif

    chk("st_we_back_to_back", we_b2b, 0);
    chk("cpu_rst_vs_busy", cpu_rst_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
